time_display_scanner: RTL and testbench

- Consumer end of the sec/min/hour counter chain: takes the binary hour, minute and second counts and drives a multiplexed 4-digit common-anode 7-segment display showing HH.MM.
- Converts the binary counts to BCD, scans one digit per refresh slot and blanks the anodes between digits to suppress ghosting.
- Blinks the HH/MM separator decimal point from the seconds count.
- Sits between the counter chain and the board display pins.

---
 rtl/time_display_scanner.sv | 142 ++++++++++++++
 tb/tb_time_display_scanner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/time_display_scanner.sv
// Purpose : drives a 4-digit common-anode 7-segment display with HH.MM taken from the
//           binary hour/min/sec counter chain, with blinking separator and anode blanking.
// Ports   : clk, reset (async, active-high); hour/min/sec binary counts in;
//           an (active-low anodes, an[0] rightmost), seg {g..a} active-low, dp active-low.
// Latency : every output is registered one cycle behind the divider/index/snapshot state.
module time_display_scanner #(
    parameter int REFRESH_DIV  = 100000,  // clock cycles per digit slot
    parameter int BLANK_CYCLES = 1000,    // leading cycles of each slot with all anodes off
    parameter int BLANK_LEAD   = 1        // 1 = suppress a zero hours-tens digit
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] BLANK_LIM = DW'(BLANK_CYCLES);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Scan state
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [5:0]    hour_q, min_q, sec_q;
    logic [5:0]    hour_d, min_d, sec_d;

    // Registered outputs
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    logic       tick;
    logic       hr_bad, mn_bad;
    logic [3:0] hr_tens, hr_units, mn_tens, mn_units;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign tick = (div_q == DIV_LAST);

    // Divider, digit index and frame snapshot. The snapshot only moves when the
    // index wraps 3->0, so all four digits of a frame come from the same time.
    always_comb begin
        div_d  = tick ? '0 : div_q + DW'(1);
        idx_d  = tick ? idx_q + 2'd1 : idx_q;
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (tick && idx_q == 2'd3) begin
            hour_d = hour;
            min_d  = min;
            sec_d  = sec;
        end
    end

    // Binary to BCD on the snapshot; 6-bit inputs never exceed 63, so tens fits 4 bits.
    always_comb begin
        hr_bad   = (hour_q > 6'd23);
        mn_bad   = (min_q  > 6'd59);
        hr_tens  = 4'(hour_q / 6'd10);
        hr_units = 4'(hour_q % 6'd10);
        mn_tens  = 4'(min_q  / 6'd10);
        mn_units = 4'(min_q  % 6'd10);
    end

    // Output selection from the current state; registered below.
    always_comb begin
        seg_d = SEG_BLANK;
        case (idx_q)
            2'd0: seg_d = mn_bad ? SEG_DASH : seg_of(mn_units);
            2'd1: seg_d = mn_bad ? SEG_DASH : seg_of(mn_tens);
            2'd2: seg_d = hr_bad ? SEG_DASH : seg_of(hr_units);
            default: begin
                if (hr_bad)
                    seg_d = SEG_DASH;
                else if (BLANK_LEAD != 0 && hr_tens == 4'd0)
                    seg_d = SEG_BLANK;
                else
                    seg_d = seg_of(hr_tens);
            end
        endcase

        // Separator lives on the hours-units digit and follows the seconds LSB.
        dp_d = !(idx_q == 2'd2 && sec_q[0]);

        // Anodes stay dark at the start of every slot so the previous digit's
        // segments never flash on the newly selected digit.
        if (div_q < BLANK_LIM)
            an_d = 4'b1111;
        else
            an_d = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            idx_q  <= 2'd0;
            hour_q <= 6'd0;
            min_q  <= 6'd0;
            sec_q  <= 6'd0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// Purpose : directed self-checking bench for time_display_scanner with a short refresh slot.
// Ports   : none; drives clk/reset/hour/min/sec and samples an/seg/dp on the falling edge.
// Flow    : reset, frame contents, anode sequence, separator, tearing, out-of-range, async reset.
module tb_time_display_scanner;

    localparam int RDIV = 8;
    localparam int BLNK = 2;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] hour, min, sec;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_err    = 0;

    logic [27:0] segs;
    logic [3:0]  dps;

    time_display_scanner #(
        .REFRESH_DIV (RDIV),
        .BLANK_CYCLES(BLNK),
        .BLANK_LEAD  (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hour (hour),
        .min  (min),
        .sec  (sec),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Wait for the first lit cycle of digit 0 (an 1111 -> 1110) on the falling edge.
    task automatic sync_frame(output bit ok);
        logic [3:0] prev;
        int n;
        ok = 1'b0;
        n  = 0;
        do begin
            prev = an;
            @(negedge clk);
            n++;
        end while (!(prev == 4'b1111 && an == 4'b1110) && n < 100);
        ok = (n < 100);
        if (!ok) chk("frame_sync_timeout", 32'(an), 32'(4'b1110));
    endtask

    // Capture seg/dp of each digit at its first lit cycle. With tear set, the
    // counters are changed once digit 2 is on screen.
    task automatic scan_frame(input bit tear, output logic [27:0] s, output logic [3:0] d);
        bit ok;
        int n;
        s = '1;
        d = '1;
        sync_frame(ok);
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                n = 0;
                while (an != ~(4'b0001 << k) && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 40) begin
                    chk("digit_wait_timeout", 32'(an), 32'(~(4'b0001 << k)));
                    break;
                end
                s[k*7 +: 7] = seg;
                d[k]        = dp;
                if (tear && k == 2) begin
                    min  = 6'd0;
                    hour = 6'd14;
                end
            end
        end
    endtask

    task automatic chk_frame(input string tag, input logic [27:0] s,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, "_d0"}, 32'(s[6:0]),   32'(e0));
        chk({tag, "_d1"}, 32'(s[13:7]),  32'(e1));
        chk({tag, "_d2"}, 32'(s[20:14]), 32'(e2));
        chk({tag, "_d3"}, 32'(s[27:21]), 32'(e3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        reset = 1'b1;
        hour  = 6'd13;
        min   = 6'd47;
        sec   = 6'd0;
        repeat (3) @(negedge clk);
        chk("reset_an",  32'(an),  32'(4'b1111));
        chk("reset_seg", 32'(seg), 32'(SB));
        chk("reset_dp",  32'(dp),  32'(1'b1));

        reset = 1'b0;
        scan_frame(1'b0, segs, dps);
        chk_frame("zero_frame", segs, SB, S0, S0, S0);
        scan_frame(1'b0, segs, dps);
        chk_frame("t1347", segs, S1, S3, S4, S7);
        chk("t1347_dp", 32'(dps), 32'(4'b1111));

        // Anode sequence over 32 cycles from the first lit cycle of digit 0
        // (third cycle of output slot 0).
        sync_frame(ok);
        for (int c = 0; c < 32; c++) begin
            int pos, slot, off;
            logic [3:0] exp_an;
            pos  = c + 2;
            slot = (pos / RDIV) % 4;
            off  = pos % RDIV;
            exp_an = (off < BLNK) ? 4'b1111 : ~(4'b0001 << slot);
            chk("an_seq", 32'(an), 32'(exp_an));
            chk("an_onehot", 32'($countones(~an) <= 1), 32'(1));
            @(negedge clk);
        end

        hour = 6'd9;
        min  = 6'd5;
        sec  = 6'd1;
        scan_frame(1'b0, segs, dps);
        scan_frame(1'b0, segs, dps);
        chk_frame("t0905", segs, SB, S9, S0, S5);
        chk("sep_on_dp", 32'(dps), 32'(4'b1011));
        sec = 6'd2;
        scan_frame(1'b0, segs, dps);
        scan_frame(1'b0, segs, dps);
        chk("sep_off_dp", 32'(dps), 32'(4'b1111));

        hour = 6'd13;
        min  = 6'd59;
        sec  = 6'd0;
        scan_frame(1'b0, segs, dps);
        scan_frame(1'b0, segs, dps);
        scan_frame(1'b1, segs, dps);
        chk_frame("tear_old", segs, S1, S3, S5, S9);
        scan_frame(1'b0, segs, dps);
        chk_frame("tear_new", segs, S1, S4, S0, S0);

        hour = 6'd30;
        min  = 6'd61;
        scan_frame(1'b0, segs, dps);
        scan_frame(1'b0, segs, dps);
        chk_frame("oor", segs, SD, SD, SD, SD);

        // Reset asserted between clock edges while digit 1 is lit.
        begin
            int n = 0;
            while (an != 4'b1101 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("mid_digit1_lit", 32'(an), 32'(4'b1101));
        end
        #1 reset = 1'b1;
        #1;
        chk("async_an",  32'(an),  32'(4'b1111));
        chk("async_seg", 32'(seg), 32'(SB));
        chk("async_dp",  32'(dp),  32'(1'b1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        scan_frame(1'b0, segs, dps);
        chk_frame("post_reset", segs, SB, S0, S0, S0);
        chk("post_reset_dp", 32'(dps), 32'(4'b1111));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
